// File: rtl/csm_shared_regfile.sv
// Two-port contended shared register file with per-register hold/release locks.
// Optional CSM_RR_ARB_EN: round-robin arbitration of same-edge hold/hold and write/write collisions.
module csm_shared_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] A_in_AD,
  input  logic              A_rw,
  input  logic              A_enable,
  input  logic              A_hold,
  input  logic              A_release,
  output logic              A_ack,
  output logic [1:0]        A_err,
  output logic [DATA_W-1:0] A_out_data,
  input  logic [DATA_W-1:0] B_in_AD,
  input  logic              B_rw,
  input  logic              B_enable,
  input  logic              B_hold,
  input  logic              B_release,
  output logic              B_ack,
  output logic [1:0]        B_err,
  output logic [DATA_W-1:0] B_out_data
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [DATA_W-1:0] NR = DATA_W'(NUM_REGS);
  localparam logic [1:0] E_OK = 2'b00, E_LOCK = 2'b01, E_ADDR = 2'b10, E_PROTO = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, WR_DATA = 2'd1, RESP = 2'd2} st_t;

  // index 0 = port A, index 1 = port B
  logic [1:0][DATA_W-1:0] in_ad;
  logic [1:0]             rw, en, hold, rel;
  assign in_ad = {B_in_AD, A_in_AD};
  assign rw    = {B_rw, A_rw};
  assign en    = {B_enable, A_enable};
  assign hold  = {B_hold, A_hold};
  assign rel   = {B_release, A_release};

  st_t                    st_q [2];
  st_t                    st_d [2];
  logic [1:0][AW-1:0]     addr_q, addr_d, in_idx;
  logic [1:0][1:0]        err_q, err_d;
  logic [1:0][DATA_W-1:0] out_q, out_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
  logic [NUM_REGS-1:0]    lock_v, lock_own;
  logic [1:0]             bad, other_lk, commit, hold_req, wr_en, lk_set, lk_clr, lose;
  logic                   wr_coll, hold_coll, win_b;

  // Per-port request decode against the registered lock table
  always_comb begin
    in_idx   = '0;
    bad      = '0;
    other_lk = '0;
    commit   = '0;
    hold_req = '0;
    for (int p = 0; p < 2; p++) begin
      in_idx[p]   = in_ad[p][AW-1:0];
      bad[p]      = in_ad[p] >= NR;
      other_lk[p] = !bad[p] && lock_v[in_idx[p]] && (lock_own[in_idx[p]] != 1'(p));
      commit[p]   = (st_q[p] == WR_DATA) &&
                    !(lock_v[addr_q[p]] && (lock_own[addr_q[p]] != 1'(p)));
      hold_req[p] = (st_q[p] == IDLE) && !en[p] && hold[p] && !rel[p] && !bad[p] && !other_lk[p];
    end
  end

  assign wr_coll   = commit[0] && commit[1] && (addr_q[0] == addr_q[1]);
  assign hold_coll = hold_req[0] && hold_req[1] && (in_idx[0] == in_idx[1]);
  assign lose      = {~win_b, win_b};

`ifdef CSM_RR_ARB_EN
  // last_b records the most recent collision winner; reset value makes A win first
  logic last_b;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                  last_b <= 1'b1;
    else if (wr_coll || hold_coll) last_b <= win_b;
  assign win_b = ~last_b;
`else
  assign win_b = 1'b0;
`endif

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    out_d  = out_q;
    wr_en  = '0;
    lk_set = '0;
    lk_clr = '0;
    for (int p = 0; p < 2; p++) begin
      st_d[p] = st_q[p];
      case (st_q[p])
        IDLE: begin
          if (en[p]) begin
            addr_d[p] = in_idx[p];
            st_d[p]   = RESP;
            if (bad[p])           err_d[p] = E_ADDR;
            else if (other_lk[p]) err_d[p] = E_LOCK;
            else if (!rw[p]) begin
              err_d[p] = E_OK;
              out_d[p] = mem_q[in_idx[p]];
            end else st_d[p] = WR_DATA;
          end else if (hold[p] || rel[p]) begin
            st_d[p] = RESP;
            if (hold[p] && rel[p])               err_d[p] = E_PROTO;
            else if (bad[p])                     err_d[p] = E_ADDR;
            else if (hold[p]) begin
              if (other_lk[p] || (hold_coll && lose[p])) err_d[p] = E_LOCK;
              else begin
                err_d[p]  = E_OK;
                lk_set[p] = 1'b1;
              end
            end else if (lock_v[in_idx[p]] && (lock_own[in_idx[p]] == 1'(p))) begin
              err_d[p]  = E_OK;
              lk_clr[p] = 1'b1;
            end else err_d[p] = E_PROTO;
          end
        end
        WR_DATA: begin
          st_d[p] = RESP;
          if (!commit[p])               err_d[p] = E_LOCK;
          else if (wr_coll && lose[p])  err_d[p] = E_PROTO;
          else begin
            err_d[p] = E_OK;
            wr_en[p] = 1'b1;
          end
        end
        RESP:    st_d[p] = IDLE;
        default: st_d[p] = IDLE;
      endcase
      if (st_d[p] == RESP && err_d[p] != E_OK) out_d[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q[0] <= IDLE;
      st_q[1] <= IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      out_q   <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      addr_q  <= addr_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  // Arbitration above guarantees no two ports write the same mem/lock entry on one edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      lock_v   <= '0;
      lock_own <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p]) mem_q[addr_q[p]] <= in_ad[p];
        if (lk_set[p]) begin
          lock_v[in_idx[p]]   <= 1'b1;
          lock_own[in_idx[p]] <= 1'(p);
        end
        if (lk_clr[p]) lock_v[in_idx[p]] <= 1'b0;
      end
    end
  end

  assign A_ack      = (st_q[0] == RESP);
  assign B_ack      = (st_q[1] == RESP);
  assign A_err      = A_ack ? err_q[0] : 2'b00;
  assign B_err      = B_ack ? err_q[1] : 2'b00;
  assign A_out_data = out_q[0];
  assign B_out_data = out_q[1];
endmodule

// File: tb/tb_csm_shared_regfile.sv
// Directed table-driven bench for csm_shared_regfile plus hand sequences for
// same-edge read/write and mid-transaction reset.
module tb_csm_shared_regfile;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] en, rw, ho, re;
  logic [7:0] ad [2];
  logic       A_ack, B_ack;
  logic [1:0] A_err, B_err;
  logic [7:0] A_out_data, B_out_data;
  logic [1:0] ack;
  logic [1:0] er [2];
  logic [7:0] od [2];

  always #5 clk = ~clk;

  csm_shared_regfile #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .A_in_AD(ad[0]), .A_rw(rw[0]), .A_enable(en[0]), .A_hold(ho[0]), .A_release(re[0]),
    .A_ack(A_ack), .A_err(A_err), .A_out_data(A_out_data),
    .B_in_AD(ad[1]), .B_rw(rw[1]), .B_enable(en[1]), .B_hold(ho[1]), .B_release(re[1]),
    .B_ack(B_ack), .B_err(B_err), .B_out_data(B_out_data)
  );

  assign ack   = {B_ack, A_ack};
  assign er[0] = A_err;
  assign er[1] = B_err;
  assign od[0] = A_out_data;
  assign od[1] = B_out_data;

`ifdef CSM_RR_ARB_EN
  localparam logic [7:0] M0 = 8'h22;
  localparam logic [1:0] E13A = 2'b11, E13B = 2'b00;
`else
  localparam logic [7:0] M0 = 8'h11;
  localparam logic [1:0] E13A = 2'b00, E13B = 2'b11;
`endif

  typedef enum logic [2:0] {NOP, RD, WR, HO, RE, HR} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] ad;
    logic [7:0] wd;
    int         lat;
    logic [1:0] err;
    logic [7:0] dat;
  } pv_t;
  typedef struct { pv_t a; pv_t b; } vec_t;

  int n_cmp = 0, n_bad = 0;
  vec_t vt [22];

  function automatic pv_t pv(op_t op, logic [7:0] a, logic [7:0] w, int lat,
                             logic [1:0] e, logic [7:0] d);
    pv_t r;
    r.op = op; r.ad = a; r.wd = w; r.lat = lat; r.err = e; r.dat = d;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h, want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    en = '0; rw = '0; ho = '0; re = '0; ad[0] = '0; ad[1] = '0;
  endtask

  // Drives both ports for one vector and watches three cycles for each ack
  task automatic run_vec(input vec_t v, input int idx);
    pv_t        p [2];
    int         ackc [2];
    int         lat_s [2];
    logic [1:0] e_s [2];
    logic [7:0] d_s [2];
    p[0] = v.a; p[1] = v.b;
    @(negedge clk);
    for (int q = 0; q < 2; q++) begin
      en[q] = (p[q].op == RD) || (p[q].op == WR);
      rw[q] = (p[q].op == WR);
      ho[q] = (p[q].op == HO) || (p[q].op == HR);
      re[q] = (p[q].op == RE) || (p[q].op == HR);
      ad[q] = p[q].ad;
      ackc[q] = 0; lat_s[q] = 0; e_s[q] = '0; d_s[q] = '0;
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        if (ack[q]) begin
          ackc[q]++; lat_s[q] = c; e_s[q] = er[q]; d_s[q] = od[q];
        end
        if (c == 1) begin
          en[q] = 1'b0; rw[q] = 1'b0; ho[q] = 1'b0; re[q] = 1'b0;
          ad[q] = (p[q].op == WR) ? p[q].wd : 8'h00;
        end else ad[q] = 8'h00;
      end
    end
    for (int q = 0; q < 2; q++) begin
      if (p[q].op == NOP) chk(q ? "B_noack" : "A_noack", idx, ackc[q], 0);
      else begin
        chk(q ? "B_ack_cycle" : "A_ack_cycle", idx, {ackc[q][15:0], lat_s[q][15:0]},
            {16'd1, p[q].lat[15:0]});
        chk(q ? "B_err" : "A_err", idx, e_s[q], p[q].err);
        chk(q ? "B_data" : "A_data", idx, d_s[q], p[q].dat);
      end
    end
  endtask

  task automatic chk_idle(input string nm, input int idx);
    chk(nm, idx, {A_ack, B_ack, A_err, B_err, A_out_data, B_out_data}, 22'h0);
  endtask

  initial begin
    pv_t n;
    vec_t v;
    n = pv(NOP, 0, 0, 0, 0, 0);
    vt[0]  = '{pv(RD, 2, 0, 1, 2'b00, 8'h00), n};
    vt[1]  = '{pv(WR, 1, 8'hFF, 2, 2'b00, 8'h00), n};
    vt[2]  = '{n, pv(RD, 1, 0, 1, 2'b00, 8'hFF)};
    vt[3]  = '{pv(HO, 3, 0, 1, 2'b00, 8'h00), n};
    vt[4]  = '{n, pv(WR, 3, 8'h5A, 1, 2'b01, 8'h00)};
    vt[5]  = '{n, pv(RD, 3, 0, 1, 2'b01, 8'h00)};
    vt[6]  = '{pv(RD, 3, 0, 1, 2'b00, 8'h00), n};
    vt[7]  = '{pv(RE, 3, 0, 1, 2'b00, 8'h00), n};
    vt[8]  = '{n, pv(WR, 3, 8'h5A, 2, 2'b00, 8'h00)};
    vt[9]  = '{n, pv(RD, 3, 0, 1, 2'b00, 8'h5A)};
    vt[10] = '{pv(RD, 7, 0, 1, 2'b10, 8'h00), n};
    vt[11] = '{n, pv(RE, 0, 0, 1, 2'b11, 8'h00)};
    vt[12] = '{pv(WR, 0, 8'h11, 2, 2'b00, 8'h00), pv(WR, 0, 8'h22, 2, 2'b11, 8'h00)};
    vt[13] = '{pv(WR, 0, 8'h11, 2, E13A, 8'h00), pv(WR, 0, 8'h22, 2, E13B, 8'h00)};
    vt[14] = '{pv(RD, 0, 0, 1, 2'b00, M0), pv(RD, 0, 0, 1, 2'b00, M0)};
    vt[15] = '{pv(HO, 2, 0, 1, 2'b00, M0), pv(HO, 2, 0, 1, 2'b01, 8'h00)};
    vt[16] = '{n, pv(WR, 2, 8'h77, 1, 2'b01, 8'h00)};
    vt[17] = '{pv(WR, 1, 8'hAB, 2, 2'b00, M0), pv(WR, 3, 8'hCD, 2, 2'b00, 8'h00)};
    vt[18] = '{pv(RD, 3, 0, 1, 2'b00, 8'hCD), pv(RD, 1, 0, 1, 2'b00, 8'hAB)};
    vt[19] = '{pv(HR, 1, 0, 1, 2'b11, 8'h00), n};
    vt[20] = '{pv(RE, 2, 0, 1, 2'b00, 8'h00), pv(HO, 2, 0, 1, 2'b01, 8'h00)};
    vt[21] = '{n, pv(HO, 2, 0, 1, 2'b00, 8'h00)};

    clear_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset_outputs", 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset_idle", 0);

    for (int i = 0; i < 22; i++) run_vec(vt[i], i);

    // B reads addr 0 on the same edge A commits its write data there
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b1; ad[0] = 8'h00;
    @(negedge clk);
    en[0] = 1'b0; rw[0] = 1'b0; ad[0] = 8'h5C;
    en[1] = 1'b1; ad[1] = 8'h00;
    @(negedge clk);
    chk("rw_same_edge_A", 100, {A_ack, A_err}, 3'b100);
    chk("rw_same_edge_B", 100, {B_ack, B_err, B_out_data}, {3'b100, M0});
    clear_inputs();
    @(negedge clk);
    chk("rw_same_edge_noack", 100, {A_ack, B_ack}, 2'b00);
    v = '{n, pv(RD, 0, 0, 1, 2'b00, 8'h5C)};
    run_vec(v, 101);

    // Reset while A is in WR_DATA with a lock held by A
    v = '{pv(HO, 0, 0, 1, 2'b00, 8'h00), n};
    run_vec(v, 200);
    @(negedge clk);
    en[0] = 1'b1; rw[0] = 1'b1; ad[0] = 8'h01;
    @(negedge clk);
    en[0] = 1'b0; rw[0] = 1'b0; ad[0] = 8'h99;
    reset_n = 1'b0;
    #1;
    chk_idle("reset_mid_write", 201);
    @(negedge clk);
    chk_idle("reset_held", 202);
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_no_ack", 203);
    v = '{n, pv(WR, 0, 8'h12, 2, 2'b00, 8'h00)};
    run_vec(v, 204);
    v = '{pv(RD, 1, 0, 1, 2'b00, 8'h00), pv(RD, 0, 0, 1, 2'b00, 8'h12)};
    run_vec(v, 205);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
